// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the in-order pipeline.
// Each architectural register has a countdown of cycles until its pending
// result is available. Issue is stalled on RAW (source not ready) and WAW
// (older write would land after the younger one). Bypass hits are reported
// when the bypass network is present, and stalled cycles are counted.
module hazard_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned MAX_LAT = 4,
    parameter int unsigned FWD_EN  = 1,
    parameter int unsigned CW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_dest,
    input  logic [CW-1:0] id_lat,
    output logic          stall,
    output logic          fwd_rs,
    output logic          fwd_rt,
    output logic          busy,
    output logic [31:0]   stall_cycles
);

    localparam logic [CW-1:0] MaxLat = CW'(MAX_LAT);
    localparam logic [CW-1:0] One    = CW'(1);
    localparam bit            HasFwd = (FWD_EN != 0);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [31:0]   stall_cycles_q;

    logic [CW-1:0] cnt_rs, cnt_rt, cnt_dest, lat_eff;
    logic          rdy_rs, rdy_rt, raw_s, raw_t, waw, issue;

    // Look up pending counts for the operands; $0 and unmapped indices read as idle.
    always_comb begin
        cnt_rs   = '0;
        cnt_rt   = '0;
        cnt_dest = '0;
        if (id_rs != '0 && 32'(id_rs) < NREG) cnt_rs = cnt_q[id_rs];
        if (id_rt != '0 && 32'(id_rt) < NREG) cnt_rt = cnt_q[id_rt];
        if (id_dest != '0 && 32'(id_dest) < NREG) cnt_dest = cnt_q[id_dest];
    end

    // Clamp the requested producer latency into 1..MAX_LAT.
    always_comb begin
        if (id_lat == '0) begin
            lat_eff = One;
        end else if (id_lat > MaxLat) begin
            lat_eff = MaxLat;
        end else begin
            lat_eff = id_lat;
        end
    end

    // Hazard detection, bypass hits and the issue decision.
    always_comb begin
        // With bypass a value one cycle from writeback is already usable.
        rdy_rs = HasFwd ? (cnt_rs <= One) : (cnt_rs == '0);
        rdy_rt = HasFwd ? (cnt_rt <= One) : (cnt_rt == '0);
        raw_s  = id_use_rs & ~rdy_rs;
        raw_t  = id_use_rt & ~rdy_rt;
        // A younger write must never complete before an older one to the same register.
        waw    = id_wr_en & (id_dest != '0) & (cnt_dest > lat_eff);
        stall  = id_valid & ~reset & (raw_s | raw_t | waw);
        fwd_rs = id_valid & id_use_rs & HasFwd & (id_rs != '0) & (cnt_rs == One);
        fwd_rt = id_valid & id_use_rt & HasFwd & (id_rt != '0) & (cnt_rt == One);
        issue  = id_valid & ~stall & id_wr_en & (id_dest != '0);
    end

    // Next countdown values: a new issue overrides the decrement of its destination.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            if (issue && id_dest == AW'(r)) begin
                cnt_d[r] = lat_eff;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - One;
            end
        end
    end

    // Any register with a result still in flight.
    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy = busy | (cnt_q[r] != '0);
        end
    end

    // Scoreboard state; reset discards every pending entry.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= reset ? '0 : cnt_d[r];
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else if (stall && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance with bypass, one without, sharing stimulus.
// Directed scenarios check hand-derived values; a random phase checks against a
// model that tracks the absolute cycle at which each register's result arrives.
module tb_hazard_scoreboard;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic             id_use_rs, id_use_rt, id_wr_en;
    logic [2:0]       id_lat;
    logic [1:0]       st, frs, frt, bsy;
    logic [1:0][31:0] sc;

    int checks;
    int errors;

    hazard_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(4), .FWD_EN(1), .CW(3)) dut_f (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_dest(id_dest), .id_lat(id_lat), .stall(st[0]), .fwd_rs(frs[0]),
        .fwd_rt(frt[0]), .busy(bsy[0]), .stall_cycles(sc[0])
    );

    hazard_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(4), .FWD_EN(0), .CW(3)) dut_n (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_dest(id_dest), .id_lat(id_lat), .stall(st[1]), .fwd_rs(frs[1]),
        .fwd_rt(frt[1]), .busy(bsy[1]), .stall_cycles(sc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input int a, input int b, input logic ua,
                          input logic ub, input logic w, input int d, input int l);
        id_valid  = v;
        id_rs     = 5'(a);
        id_rt     = 5'(b);
        id_use_rs = ua;
        id_use_rt = ub;
        id_wr_en  = w;
        id_dest   = 5'(d);
        id_lat    = 3'(l);
    endtask

    task automatic set_idle();
        set_in(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b1, 3, 4, 1'b1, 1'b1, 1'b1, 5, 2);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (st[i] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b expected 0", i, st[i]); end
            checks++;
            if ({frs[i], frt[i]} !== 2'b00) begin errors++; $display("FAIL reset_fwd[%0d]: got %b expected 00", i, {frs[i], frt[i]}); end
            checks++;
            if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, bsy[i]); end
            checks++;
            if (sc[i] !== 32'd0) begin errors++; $display("FAIL reset_sc[%0d]: got %0h expected 0", i, sc[i]); end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_fwd_lat1();
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1);
        @(negedge clk);
        set_in(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 4, 1);
        #1;
        checks++;
        if (st[0] !== 1'b0) begin errors++; $display("FAIL lat1_fwd_stall: got %b expected 0", st[0]); end
        checks++;
        if ({frs[0], frt[0]} !== 2'b11) begin errors++; $display("FAIL lat1_fwd_hits: got %b expected 11", {frs[0], frt[0]}); end
        checks++;
        if (st[1] !== 1'b1) begin errors++; $display("FAIL lat1_nofwd_stall: got %b expected 1", st[1]); end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (sc[0] !== 32'd0) begin errors++; $display("FAIL lat1_fwd_sc: got %0d expected 0", sc[0]); end
    endtask

    task automatic test_load_use();
        int n;
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 2);
        @(negedge clk);
        set_in(1'b1, 5, 0, 1'b1, 1'b0, 1'b1, 6, 1);
        #1;
        n = 0;
        while (st[0] === 1'b1 && n < 12) begin @(negedge clk); #1; n++; end
        checks++;
        if (n !== 1) begin errors++; $display("FAIL load_use_stalls: got %0d expected 1", n); end
        checks++;
        if (frs[0] !== 1'b1) begin errors++; $display("FAIL load_use_fwd: got %b expected 1", frs[0]); end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (sc[0] !== 32'd1) begin errors++; $display("FAIL load_use_sc: got %0d expected 1", sc[0]); end
    endtask

    task automatic test_nofwd_mult();
        int   n;
        logic any_fwd, last_busy;
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8, 4);
        @(negedge clk);
        set_in(1'b1, 8, 8, 1'b1, 1'b1, 1'b0, 0, 1);
        #1;
        n = 0;
        any_fwd = 1'b0;
        last_busy = 1'b0;
        while (st[1] === 1'b1 && n < 12) begin
            any_fwd = any_fwd | frs[1] | frt[1];
            last_busy = bsy[1];
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL mult_nofwd_stalls: got %0d expected 4", n); end
        checks++;
        if ((any_fwd | frs[1] | frt[1]) !== 1'b0) begin errors++; $display("FAIL mult_nofwd_fwd: got 1 expected 0"); end
        checks++;
        if (last_busy !== 1'b1) begin errors++; $display("FAIL mult_busy_held: got %b expected 1", last_busy); end
        checks++;
        if (bsy[1] !== 1'b0) begin errors++; $display("FAIL mult_busy_drop: got %b expected 0", bsy[1]); end
        checks++;
        if (sc[1] !== 32'd4) begin errors++; $display("FAIL mult_sc: got %0d expected 4", sc[1]); end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_waw();
        int n;
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 4);
        @(negedge clk);
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1);
        #1;
        n = 0;
        // Counts seen are 4,3,2 (all > 1) before the younger write may go.
        while (st[0] === 1'b1 && n < 12) begin @(negedge clk); #1; n++; end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL waw_stalls: got %0d expected 3", n); end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL waw_busy_after: got %b expected 1", bsy[0]); end
        @(negedge clk);
        #1;
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL waw_busy_clear: got %b expected 0", bsy[0]); end
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 4);
        #1;
        checks++;
        if (st !== 2'b00) begin errors++; $display("FAIL zero_dest_stall: got %b expected 00", st); end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (bsy !== 2'b00) begin errors++; $display("FAIL zero_dest_busy: got %b expected 00", bsy); end
    endtask

    task automatic test_clamp();
        int n;
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 10, 0);
        @(negedge clk);
        set_in(1'b1, 10, 0, 1'b1, 1'b0, 1'b0, 0, 0);
        #1;
        checks++;
        if ({st[0], frs[0]} !== 2'b01) begin errors++; $display("FAIL lat0_fwd: got %b expected 01", {st[0], frs[0]}); end
        checks++;
        if (st[1] !== 1'b1) begin errors++; $display("FAIL lat0_nofwd_stall: got %b expected 1", st[1]); end
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 11, 7);
        @(negedge clk);
        set_in(1'b1, 0, 11, 1'b0, 1'b1, 1'b0, 0, 0);
        #1;
        n = 0;
        while (st[0] === 1'b1 && n < 12) begin @(negedge clk); #1; n++; end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL lat7_stalls: got %0d expected 3", n); end
        checks++;
        if (frt[0] !== 1'b1) begin errors++; $display("FAIL lat7_fwd: got %b expected 1", frt[0]); end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 12, 4);
        @(negedge clk);
        set_in(1'b1, 12, 0, 1'b1, 1'b0, 1'b1, 14, 1);
        #1;
        checks++;
        if (st[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b expected 1", st[0]); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (st !== 2'b00) begin errors++; $display("FAIL mid_reset_mask: got %b expected 00", st); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({st[0], bsy[0]} !== 2'b00) begin errors++; $display("FAIL mid_after_reset: got %b expected 00", {st[0], bsy[0]}); end
        checks++;
        if (sc[0] !== 32'd0) begin errors++; $display("FAIL mid_sc_clear: got %0d expected 0", sc[0]); end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL mid_consumer_issued: got %b expected 1", bsy[0]); end
    endtask

    task automatic test_saturate();
        int n;
        pulse_reset();
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 13, 4);
        @(negedge clk);
        set_in(1'b1, 13, 0, 1'b1, 1'b0, 1'b0, 0, 1);
        #1;
        force dut_n.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut_n.stall_cycles_q;
        @(negedge clk);
        #1;
        checks++;
        if (sc[1] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_step: got %0h expected fffffffe", sc[1]); end
        n = 0;
        while (st[1] === 1'b1 && n < 12) begin @(negedge clk); #1; n++; end
        checks++;
        if (sc[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffffffff", sc[1]); end
        @(negedge clk);
        set_idle();
    endtask

    // Model: avail[r] is the absolute cycle at which register r's count reaches zero.
    task automatic test_random();
        longint      now;
        longint      avail [2][32];
        logic [31:0] msc [2];
        pulse_reset();
        now = 0;
        for (int i = 0; i < 2; i++) begin
            msc[i] = '0;
            for (int r = 0; r < 32; r++) avail[i][r] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            logic rst, v, ua, ub, w;
            int   a, b, d, l, lat;
            rst = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 7) != 0);
            a   = $urandom_range(0, 7);
            b   = $urandom_range(0, 7);
            d   = $urandom_range(0, 7);
            ua  = 1'($urandom_range(0, 1));
            ub  = 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 3) != 0);
            l   = $urandom_range(0, 7);
            reset = rst;
            set_in(v, a, b, ua, ub, w, d, l);
            #1;
            lat = (l == 0) ? 1 : ((l > 4) ? 4 : l);
            for (int i = 0; i < 2; i++) begin
                int   ca, cb, cd;
                logic ra, rb, es, efs, eft, eb;
                ca = (a == 0 || avail[i][a] <= now) ? 0 : int'(avail[i][a] - now);
                cb = (b == 0 || avail[i][b] <= now) ? 0 : int'(avail[i][b] - now);
                cd = (d == 0 || avail[i][d] <= now) ? 0 : int'(avail[i][d] - now);
                ra = (i == 0) ? (ca <= 1) : (ca == 0);
                rb = (i == 0) ? (cb <= 1) : (cb == 0);
                es = v && !rst && ((ua && !ra) || (ub && !rb) || (w && d != 0 && cd > lat));
                efs = v && ua && (i == 0) && a != 0 && ca == 1;
                eft = v && ub && (i == 0) && b != 0 && cb == 1;
                eb = 1'b0;
                for (int r = 1; r < 32; r++) if (avail[i][r] > now) eb = 1'b1;
                checks++;
                if (st[i] !== es) begin errors++; $display("FAIL rnd_stall[%0d] c%0d: got %b expected %b", i, c, st[i], es); end
                checks++;
                if (frs[i] !== efs) begin errors++; $display("FAIL rnd_fwd_rs[%0d] c%0d: got %b expected %b", i, c, frs[i], efs); end
                checks++;
                if (frt[i] !== eft) begin errors++; $display("FAIL rnd_fwd_rt[%0d] c%0d: got %b expected %b", i, c, frt[i], eft); end
                checks++;
                if (bsy[i] !== eb) begin errors++; $display("FAIL rnd_busy[%0d] c%0d: got %b expected %b", i, c, bsy[i], eb); end
                checks++;
                if (sc[i] !== msc[i]) begin errors++; $display("FAIL rnd_sc[%0d] c%0d: got %0d expected %0d", i, c, sc[i], msc[i]); end
                if (rst) begin
                    msc[i] = '0;
                    for (int r = 0; r < 32; r++) avail[i][r] = 0;
                end else begin
                    if (es && msc[i] != 32'hFFFF_FFFF) msc[i] = msc[i] + 32'd1;
                    if (v && !es && w && d != 0) avail[i][d] = now + 1 + lat;
                end
            end
            now++;
            @(negedge clk);
        end
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_fwd_lat1();
        test_load_use();
        test_nofwd_mult();
        test_waw();
        test_clamp();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
